gbar_collector: RTL

- Cluster-level responder for the global-barrier bus; each core's warp scheduler is the requester.
- Gathers barrier-arrival requests from `NUM_REQS` requester ports, one accepted per cycle under round-robin arbitration.
- Keeps a per-barrier mask of arrived cores.
- When the last expected core arrives, broadcasts a one-cycle release response carrying the barrier id back to all cores.

---
 rtl/gbar_collector_pkg.sv | 25 ++
 rtl/gbar_rr_arbiter.sv | 44 ++++
 rtl/gbar_collector.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/gbar_collector_pkg.sv
// Shared types and widths for the global-barrier collector.
// Optional GBAR_PERF_EN build adds performance counters to gbar_collector.
package gbar_collector_pkg;

    localparam int GBAR_NUM_CORES    = 4;
    localparam int GBAR_NUM_BARRIERS = 4;

    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    localparam int NB_WIDTH = clog2_min1(GBAR_NUM_BARRIERS);
    localparam int NC_WIDTH = clog2_min1(GBAR_NUM_CORES);

    typedef struct packed {
        logic [NB_WIDTH-1:0] id;
        logic [NC_WIDTH-1:0] size_m1;
        logic [NC_WIDTH-1:0] core_id;
    } gbar_req_data_t;

    typedef struct packed {
        logic [NB_WIDTH-1:0] id;
    } gbar_rsp_data_t;

endpackage

// File: rtl/gbar_rr_arbiter.sv
// Round-robin arbiter: search starts at a registered pointer, onehot grant plus index.
// The pointer moves past the granted port only when i_en reports a transfer.
module gbar_rr_arbiter
    import gbar_collector_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int IDX_W    = clog2_min1(NUM_REQS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] i_req,
    input  logic                i_en,
    output logic [NUM_REQS-1:0] o_grant,
    output logic [IDX_W-1:0]    o_grant_idx,
    output logic                o_grant_any
);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_idx;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_grant_any = 1'b0;
        w_idx       = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            w_idx = IDX_W'((int'(r_ptr) + i) % NUM_REQS);
            if (!o_grant_any && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = w_idx;
                o_grant_any    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (i_en) begin
            r_ptr <= (int'(o_grant_idx) == NUM_REQS - 1) ? '0 : o_grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/gbar_collector.sv
// Global-barrier collector: accepts one arrival per cycle, tracks per-barrier core masks,
// pulses rsp_valid/rsp_id one cycle after the last arrival. GBAR_PERF_EN adds perf counters.
module gbar_collector
    import gbar_collector_pkg::clog2_min1, gbar_collector_pkg::gbar_req_data_t;
#(
    parameter int NUM_REQS     = 4,
    parameter int NUM_CORES    = 4,
    parameter int NUM_BARRIERS = 4,
    parameter int NB_WIDTH     = clog2_min1(NUM_BARRIERS),
    parameter int NC_WIDTH     = clog2_min1(NUM_CORES)
`ifdef GBAR_PERF_EN
    ,
    parameter int PERF_CTR_BITS = 32
`endif
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQS-1:0]          req_valid,
    input  logic [NUM_REQS*NB_WIDTH-1:0] req_id,
    input  logic [NUM_REQS*NC_WIDTH-1:0] req_size_m1,
    input  logic [NUM_REQS*NC_WIDTH-1:0] req_core_id,
    output logic [NUM_REQS-1:0]          req_ready,
    output logic                         rsp_valid,
    output logic [NB_WIDTH-1:0]          rsp_id
`ifdef GBAR_PERF_EN
    ,
    output logic [PERF_CTR_BITS-1:0]     perf_releases,
    output logic [PERF_CTR_BITS-1:0]     perf_wait_cycles
`endif
);

    localparam int RIDX_W = clog2_min1(NUM_REQS);
    localparam int CNT_W  = $clog2(NUM_CORES + 1);

    logic [NUM_REQS-1:0]  w_grant;
    logic [RIDX_W-1:0]    w_grant_idx;
    logic                 w_grant_any;
    logic                 w_accept;
    gbar_req_data_t       w_sel;
    logic [NUM_CORES-1:0] w_cur;
    logic [NUM_CORES-1:0] w_bit;
    logic [NUM_CORES-1:0] w_new;
    logic [CNT_W-1:0]     w_cnt;
    logic                 w_core_ok;
    logic                 w_id_ok;
    logic                 w_dup;
    logic                 w_release;

    logic [NUM_CORES-1:0] r_mask [NUM_BARRIERS];
    logic                 r_rsp_valid;
    logic [NB_WIDTH-1:0]  r_rsp_id;

    gbar_rr_arbiter #(
        .NUM_REQS (NUM_REQS)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .i_req       (req_valid),
        .i_en        (w_accept),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_grant_any (w_grant_any)
    );

    // Valid/ready: a port transfers on the cycle its req_valid and req_ready are both high;
    // the requester keeps its fields stable until then. Nothing is granted while in reset.
    assign req_ready = reset ? '0 : w_grant;
    assign w_accept  = w_grant_any && !reset;

    always_comb begin
        w_sel.id      = req_id[int'(w_grant_idx)*NB_WIDTH +: NB_WIDTH];
        w_sel.size_m1 = req_size_m1[int'(w_grant_idx)*NC_WIDTH +: NC_WIDTH];
        w_sel.core_id = req_core_id[int'(w_grant_idx)*NC_WIDTH +: NC_WIDTH];
        w_id_ok       = int'(w_sel.id) < NUM_BARRIERS;
        w_core_ok     = int'(w_sel.core_id) < NUM_CORES;
        w_cur         = '0;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            if (int'(w_sel.id) == b) w_cur = r_mask[b];
        end
        w_bit = w_core_ok ? (NUM_CORES'(1) << w_sel.core_id) : '0;
        w_new = w_cur | w_bit;
        w_cnt = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            w_cnt = w_cnt + CNT_W'(w_new[c]);
        end
        // An arrival that adds no bit (duplicate or out-of-range core) never releases.
        w_dup     = (w_new == w_cur);
        w_release = w_accept && w_id_ok && !w_dup && (int'(w_cnt) >= int'(w_sel.size_m1) + 1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < NUM_BARRIERS; b++) r_mask[b] <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
        end else begin
            r_rsp_valid <= w_release;
            if (w_release) r_rsp_id <= w_sel.id;
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                if (w_accept && !w_dup && int'(w_sel.id) == b) begin
                    r_mask[b] <= w_release ? '0 : w_new;
                end
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;

    always @(posedge clk) begin
        if (!reset && w_accept) begin
            assert (w_core_ok) else $warning("gbar: core id out of range");
            assert ((w_cur & w_bit) == '0) else $warning("gbar: duplicate core arrival");
            assert (int'(w_cnt) <= int'(w_sel.size_m1) + 1) else $warning("gbar: arrival count above size");
        end
    end

`ifdef GBAR_PERF_EN
    logic                     w_any_pending;
    logic [PERF_CTR_BITS-1:0] r_perf_releases;
    logic [PERF_CTR_BITS-1:0] r_perf_wait_cycles;

    always_comb begin
        w_any_pending = 1'b0;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            if (r_mask[b] != '0) w_any_pending = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_releases    <= '0;
            r_perf_wait_cycles <= '0;
        end else begin
            if (w_release)     r_perf_releases    <= r_perf_releases + 1'b1;
            if (w_any_pending) r_perf_wait_cycles <= r_perf_wait_cycles + 1'b1;
        end
    end

    assign perf_releases    = r_perf_releases;
    assign perf_wait_cycles = r_perf_wait_cycles;
`endif

endmodule
